bk_pipe_adder: RTL and testbench

Parametrised, two-stage pipelined Brent-Kung adder/subtractor with valid/ready flow control. It is the successor to the fixed 32-bit combinational Brent-Kung adder. It is generalised to any power-of-two WIDTH, adds a subtract mode, and registers the prefix tree so the datapath can close timing at full ALU clock rate. It sits between the ALU operand mux and the result writeback stage and sustains one operation per cycle.

---
 rtl/bk_pipe_adder.sv | 134 +++++++++++++
 tb/tb_bk_pipe_adder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_pipe_adder.sv
// bk_pipe_adder: two-stage pipelined Brent-Kung adder/subtractor with
// valid/ready flow control. S1 registers generate/propagate, the prefix
// tree sits between S1 and S2, S2 registers the result.
// Optional feature macro: BK_PIPE_FLAGS_EN adds registered ovf/zero outputs.
module bk_pipe_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef BK_PIPE_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);

    localparam int unsigned LOG = $clog2(WIDTH);

    if (WIDTH < 4 || WIDTH > 128 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("bk_pipe_adder: WIDTH must be a power of two in 4..128");
    end

    logic             v1_q, v2_q;
    logic [WIDTH-1:0] g_q, p_q;
    logic             cin_q;
    logic [WIDTH-1:0] g_d, p_d;
    logic             adv1, adv2, accept;
    logic [WIDTH-1:0] gt, pt;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;

    // Flow control: a stage advances when it is empty or its consumer advances.
    always_comb begin
        adv2     = !v2_q || out_ready;
        adv1     = !v1_q || adv2;
        in_ready = adv1 && !rst;
        accept   = in_valid && in_ready;
    end

    // Operand mux and bitwise generate/propagate.
    always_comb begin
        g_d = inA & (sub ? ~inB : inB);
        p_d = inA ^ (sub ? ~inB : inB);
    end

    // S1 register: generate/propagate, carry-in and valid; holds when stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            g_q   <= '0;
            p_q   <= '0;
            cin_q <= 1'b0;
        end else if (adv1) begin
            v1_q  <= accept;
            g_q   <= g_d;
            p_q   <= p_d;
            cin_q <= cin;
        end
    end

    // Brent-Kung prefix over {g[W-2:0],cin}/{p[W-2:0],1}; gt[i] ends as the carry into bit i.
    // Up-sweep combines at positions i+1 = k*2^(l+1); down-sweep fills the odd midpoints.
    always_comb begin
        gt = {g_q[WIDTH-2:0], cin_q};
        pt = {p_q[WIDTH-2:0], 1'b1};
        for (int unsigned l = 0; l < LOG; l++) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (32'd1 << (l + 1))) == 0) begin
                    gt[i] = gt[i] | (pt[i] & gt[i - (32'd1 << l)]);
                    pt[i] = pt[i] & pt[i - (32'd1 << l)];
                end
            end
        end
        for (int unsigned l = LOG - 1; l > 0; l--) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (32'd1 << l)) == (32'd1 << (l - 1)) && i >= (32'd1 << l)) begin
                    gt[i] = gt[i] | (pt[i] & gt[i - (32'd1 << (l - 1))]);
                end
            end
        end
    end

    // Result and carry-out from the prefix carries.
    always_comb begin
        sum_d  = p_q ^ gt;
        cout_d = g_q[WIDTH-1] | (p_q[WIDTH-1] & gt[WIDTH-1]);
    end

    // S2 register: result, carry-out and valid; holds when stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q   <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (adv2) begin
            v2_q   <= v1_q;
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

`ifdef BK_PIPE_FLAGS_EN
    logic ovf_q, zero_q;

    // Flags registered alongside the sum: signed overflow and zero result.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv2) begin
            ovf_q  <= gt[WIDTH-1] ^ cout_d;
            zero_q <= ~|sum_d;
        end
    end

    assign ovf  = ovf_q;
    assign zero = zero_q;
`endif

    assign out_valid = v2_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_bk_pipe_adder.sv
// Testbench for bk_pipe_adder: directed cases, backpressure and random
// streams at WIDTH=32, mid-stream reset, and random sweeps at 4/8/64/128.
// Results are compared against an arithmetic reference model in a queue.
module tb_bk_pipe_adder;

    localparam int W      = 32;
    localparam int NSWEEP = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [131:0] got, input logic [131:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic          rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [W-1:0]  inA, inB, sum;
`ifdef BK_PIPE_FLAGS_EN
    logic          ovf, zero;
`endif

    bk_pipe_adder #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inA(inA), .inB(inB), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef BK_PIPE_FLAGS_EN
        , .ovf(ovf), .zero(zero)
`endif
    );

    // Reference: {ovf, zero, cout, sum} of a + (sb ? ~b : b) + ci.
    function automatic logic [W+2:0] model32(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic ci, input logic sb);
        logic [W-1:0] bb;
        logic [W:0]   e;
        logic         ov;
        bb = sb ? ~b : b;
        e  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
        ov = (a[W-1] == bb[W-1]) && (e[W-1] != a[W-1]);
        return {ov, (e[W-1:0] == '0), e};
    endfunction

    function automatic logic [W+2:0] obs32();
`ifdef BK_PIPE_FLAGS_EN
        return {ovf, zero, cout, sum};
`else
        return {2'b00, cout, sum};
`endif
    endfunction

    function automatic logic [W+2:0] msk32(input logic [W+2:0] e);
`ifdef BK_PIPE_FLAGS_EN
        return e;
`else
        return {2'b00, e[W:0]};
`endif
    endfunction

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic sb, input logic [W+2:0] exp);
        @(negedge clk);
        in_valid = 1'b1; inA = a; inB = b; cin = ci; sub = sb; out_ready = 1'b1;
        #4 check({tag, "_rdy"}, 132'(in_ready), 132'(1));
        @(negedge clk);
        in_valid = 1'b0;
        #4 check({tag, "_lat1"}, 132'(out_valid), 132'(0));
        @(negedge clk);
        #4 check({tag, "_vld"}, 132'(out_valid), 132'(1));
        check(tag, 132'(obs32()), 132'(msk32(exp)));
    endtask

    task automatic stream(input string tag, input int n, input bit bp);
        logic [W+2:0] q[$];
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        while (got < n && cyc < 2000) begin
            @(negedge clk);
            in_valid  = (sent < n) && (bp || $urandom_range(3) != 0);
            inA       = $urandom();
            inB       = $urandom();
            cin       = 1'($urandom_range(1));
            sub       = 1'($urandom_range(1));
            out_ready = bp ? !(cyc >= 3 && cyc <= 7) : ($urandom_range(3) != 0);
            #4;
            check({tag, "_in_ready"}, 132'(in_ready), 132'(!(q.size() == 2 && !out_ready)));
            if (out_valid && out_ready) begin
                if (q.size() == 0) check({tag, "_spurious"}, 132'(1), 132'(0));
                else check({tag, "_res"}, 132'(obs32()), 132'(msk32(q.pop_front())));
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model32(inA, inB, cin, sub));
                sent++;
            end
            cyc++;
        end
        check({tag, "_count"}, 132'(got), 132'(n));
        in_valid = 1'b0;
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
        localparam int SW = (gi == 0) ? 4 : (gi == 1) ? 8 : (gi == 2) ? 64 : 128;
        logic          s_rst, s_iv, s_ir, s_ci, s_sb, s_ov, s_or, s_co;
        logic [SW-1:0] s_a, s_b, s_s;
`ifdef BK_PIPE_FLAGS_EN
        logic          s_ovf, s_zero;
`endif
        bit            done = 1'b0;

        bk_pipe_adder #(.WIDTH(SW)) u_dut (
            .clk(clk), .rst(s_rst), .in_valid(s_iv), .in_ready(s_ir),
            .inA(s_a), .inB(s_b), .cin(s_ci), .sub(s_sb),
            .out_valid(s_ov), .out_ready(s_or), .sum(s_s), .cout(s_co)
`ifdef BK_PIPE_FLAGS_EN
            , .ovf(s_ovf), .zero(s_zero)
`endif
        );

        function automatic logic [SW+2:0] mdl(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                              input logic ci, input logic sb);
            logic [SW-1:0] bb;
            logic [SW:0]   e;
            logic          ov;
            bb = sb ? ~b : b;
            e  = {1'b0, a} + {1'b0, bb} + {{SW{1'b0}}, ci};
            ov = (a[SW-1] == bb[SW-1]) && (e[SW-1] != a[SW-1]);
            return {ov, (e[SW-1:0] == '0), e};
        endfunction

        function automatic logic [SW+2:0] obs();
`ifdef BK_PIPE_FLAGS_EN
            return {s_ovf, s_zero, s_co, s_s};
`else
            return {2'b00, s_co, s_s};
`endif
        endfunction

        function automatic logic [SW+2:0] msk(input logic [SW+2:0] e);
`ifdef BK_PIPE_FLAGS_EN
            return e;
`else
            return {2'b00, e[SW:0]};
`endif
        endfunction

        initial begin
            logic [SW+2:0] q[$];
            int sent, got, cyc;
            sent = 0; got = 0; cyc = 0;
            s_rst = 1'b1; s_iv = 1'b0; s_or = 1'b0;
            s_a = '0; s_b = '0; s_ci = 1'b0; s_sb = 1'b0;
            repeat (2) @(negedge clk);
            s_rst = 1'b0;
            while (got < NSWEEP && cyc < 60000) begin
                @(negedge clk);
                s_iv = (sent < NSWEEP) && ($urandom_range(3) != 0);
                if ($urandom_range(7) == 0) begin
                    s_a = '1; s_b = '0; s_ci = 1'b1; s_sb = 1'b0;
                end else begin
                    s_a  = SW'({$urandom(), $urandom(), $urandom(), $urandom()});
                    s_b  = SW'({$urandom(), $urandom(), $urandom(), $urandom()});
                    s_ci = 1'($urandom_range(1));
                    s_sb = 1'($urandom_range(1));
                end
                s_or = ($urandom_range(3) != 0);
                #4;
                check($sformatf("w%0d_in_ready", SW), 132'(s_ir), 132'(!(q.size() == 2 && !s_or)));
                if (s_ov && s_or) begin
                    if (q.size() == 0) check($sformatf("w%0d_spurious", SW), 132'(1), 132'(0));
                    else check($sformatf("w%0d_res", SW), 132'(obs()), 132'(msk(q.pop_front())));
                    got++;
                end
                if (s_iv && s_ir) begin
                    q.push_back(mdl(s_a, s_b, s_ci, s_sb));
                    sent++;
                end
                cyc++;
            end
            check($sformatf("w%0d_count", SW), 132'(got), 132'(NSWEEP));
            s_iv = 1'b0;
            done = 1'b1;
        end
    end

    initial begin
        int wait_cyc;
        rst = 1'b1; in_valid = 1'b1; inA = $urandom(); inB = $urandom();
        cin = 1'b1; sub = 1'b0; out_ready = 1'b1;

        // Reset held three cycles with in_valid high.
        repeat (3) begin
            @(negedge clk);
            #4;
            check("rst_in_ready", 132'(in_ready), 132'(0));
            check("rst_out_valid", 132'(out_valid), 132'(0));
            check("rst_outputs", 132'(obs32()), '0);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #4 check("rdy_after_rst", 132'(in_ready), 132'(1));

        // Directed: expected = {ovf, zero, cout, sum}.
        directed("wrap",    32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, {1'b0, 1'b1, 1'b1, 32'h00000000});
        directed("sub5m7",  32'h00000005, 32'h00000007, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, 32'hFFFFFFFE});
        directed("minm1",   32'h80000000, 32'h00000001, 1'b1, 1'b1, {1'b1, 1'b0, 1'b1, 32'h7FFFFFFF});
        directed("maxp1",   32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b0, 32'h80000000});
        directed("ripple",  32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 32'h00010000});
        directed("subeq",   32'h00001234, 32'h00001234, 1'b1, 1'b1, {1'b0, 1'b1, 1'b1, 32'h00000000});

        stream("bp", 10, 1'b1);
        stream("rnd", 300, 1'b0);

        // Mid-stream reset: two beats in flight are discarded.
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b0; inA = $urandom(); inB = $urandom();
        #4 check("mid_acc1", 132'(in_ready), 132'(1));
        @(negedge clk);
        inA = $urandom();
        #4 check("mid_acc2", 132'(in_ready), 132'(1));
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        #4 check("mid_rst_rdy", 132'(in_ready), 132'(0));
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #4 check("mid_rst_ov0", 132'(out_valid), 132'(0));
        repeat (2) begin
            @(negedge clk);
            #4 check("mid_rst_ovq", 132'(out_valid), 132'(0));
        end
        directed("post_rst", 32'h12345678, 32'h11111111, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 32'h23456789});

        wait_cyc = 0;
        while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done)
               && wait_cyc < 80000) begin
            @(posedge clk);
            wait_cyc++;
        end
        check("sweep_done",
              132'({g_sweep[0].done, g_sweep[1].done, g_sweep[2].done, g_sweep[3].done}),
              132'(4'hF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
